// File: rtl/rr_select_pkg.sv
// Shared types and constants for the round-robin select encoder:
// FSM state enum, request/select widths and a 3-to-8 one-hot helper.
package rr_select_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-find: first set request at or after ptr
// (wrapping 7 -> 0). With no request, idx falls back to ptr so it is never X.
module rr_pick
  import rr_select_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] k;

  // Walk from the farthest offset down so the nearest hit to ptr is kept last.
  always_comb begin
    idx = ptr;
    k   = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) idx = k;
    end
    any = |req;
  end

endmodule

// File: rtl/rr_select_encoder.sv
// Round-robin 8-to-3 select encoder with valid/ready offer and optional timeout.
// Define RR_SELECT_LOCK_EN to keep re-offering a channel while it still requests.
module rr_select_encoder
  import rr_select_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_valid,
  input  logic                 sel_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] wait_cnt;

  logic             handshake;
  logic             expire;
  logic [SEL_W-1:0] adv_ptr;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  // Handshake: a transfer happens on a rising edge where sel_valid and
  // sel_ready are both high; once raised, sel/sel_valid stay put until that
  // transfer or a timeout withdraws the offer.
  assign handshake = sel_valid & sel_ready;
  assign adv_ptr   = sel + 1'b1;

`ifdef RR_SELECT_LOCK_EN
  assign next_ptr = req[sel] ? sel : adv_ptr;
`else
  assign next_ptr = adv_ptr;
`endif

  // On a handshake the re-pick already uses the post-grant pointer.
  assign pick_ptr = handshake ? next_ptr : ptr;
  assign expire   = (TIMEOUT_CYC > 0) && !handshake && (wait_cnt == CNT_LAST);

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      grant     <= '0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      grant   <= '0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel       <= pick_idx;
            sel_valid <= 1'b1;
            wait_cnt  <= '0;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (handshake) begin
            grant    <= onehot(sel);
            ptr      <= next_ptr;
            wait_cnt <= '0;
            if (pick_any) begin
              sel <= pick_idx;
            end else begin
              sel_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (expire) begin
            sel_valid <= 1'b0;
            timeout   <= 1'b1;
            ptr       <= adv_ptr;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_select_encoder.sv
// Directed bench for rr_select_encoder (TIMEOUT_CYC=15); lock-mode section
// follows RR_SELECT_LOCK_EN when the bench is built with it.
module tb_rr_select_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic [7:0] grant;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_select_encoder #(.TIMEOUT_CYC(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .grant     (grant),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may be changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 8'h00;
    sel_ready = 1'b0;
    cyc();
    cyc();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(sel_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_valid", 32'(sel_valid), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
    end

    // Reset in the middle of an offer
    req = 8'h10;
    cyc();
    check("pre_rst_valid", 32'(sel_valid), 32'd1);
    check("pre_rst_sel", 32'(sel), 32'd4);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_valid", 32'(sel_valid), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    req   = 8'h00;
    cyc();

`ifndef RR_SELECT_LOCK_EN
    // All requesting, always ready: full rotation
    req       = 8'hFF;
    sel_ready = 1'b1;
    cyc();
    check("ff_sel0", 32'(sel), 32'd0);
    check("ff_grant0", 32'(grant), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check("ff_sel", 32'(sel), 32'(i % 8));
      check("ff_grant", 32'(grant), 32'(8'd1 << ((i - 1) % 8)));
      check("ff_valid", 32'(sel_valid), 32'd1);
    end
    req = 8'h00;
    cyc();
    check("ff_end_grant", 32'(grant), 32'h02);
    check("ff_end_valid", 32'(sel_valid), 32'd0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Wrap-around between channels 0 and 7
    req = 8'h81;
    cyc();
    check("w_sel0", 32'(sel), 32'd0);
    cyc();
    check("w_grant_a", 32'(grant), 32'h01);
    check("w_sel_a", 32'(sel), 32'd7);
    cyc();
    check("w_grant_b", 32'(grant), 32'h80);
    check("w_sel_b", 32'(sel), 32'd0);
    cyc();
    check("w_grant_c", 32'(grant), 32'h01);
    check("w_sel_c", 32'(sel), 32'd7);
    cyc();
    check("w_grant_d", 32'(grant), 32'h80);
    check("w_sel_d", 32'(sel), 32'd0);
    req = 8'h00;
    cyc();
    check("w_grant_e", 32'(grant), 32'h01);
    check("w_valid_e", 32'(sel_valid), 32'd0);
    cyc();
`endif

    // Stalled consumer, request dropped during the stall
    sel_ready = 1'b0;
    req       = 8'h10;
    cyc();
    check("st_sel", 32'(sel), 32'd4);
    check("st_valid", 32'(sel_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("st_hold_sel", 32'(sel), 32'd4);
      check("st_hold_valid", 32'(sel_valid), 32'd1);
      check("st_hold_grant", 32'(grant), 32'd0);
      if (i == 0) req = 8'h00;
    end
    sel_ready = 1'b1;
    cyc();
    check("st_grant", 32'(grant), 32'h10);
    check("st_valid_end", 32'(sel_valid), 32'd0);
    cyc();
    check("st_grant_once", 32'(grant), 32'd0);

    // Timeout withdraws a 15-cycle offer; ptr=5 here so channel 1 is picked
    sel_ready = 1'b0;
    req       = 8'h06;
    cyc();
    check("to_sel", 32'(sel), 32'd1);
    check("to_valid", 32'(sel_valid), 32'd1);
    for (int i = 0; i < 14; i++) begin
      cyc();
      check("to_hold_sel", 32'(sel), 32'd1);
      check("to_hold_valid", 32'(sel_valid), 32'd1);
      check("to_hold_timeout", 32'(timeout), 32'd0);
    end
    cyc();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_valid_drop", 32'(sel_valid), 32'd0);
    check("to_no_grant", 32'(grant), 32'd0);
    cyc();
    check("to_next_sel", 32'(sel), 32'd2);
    check("to_next_valid", 32'(sel_valid), 32'd1);
    check("to_pulse_end", 32'(timeout), 32'd0);

    // Ready on the expiry cycle: handshake wins
    for (int i = 0; i < 14; i++) begin
      cyc();
      check("hx_hold_sel", 32'(sel), 32'd2);
    end
    sel_ready = 1'b1;
    cyc();
    check("hx_grant", 32'(grant), 32'h04);
    check("hx_timeout", 32'(timeout), 32'd0);
    check("hx_sel", 32'(sel), 32'd1);
    check("hx_valid", 32'(sel_valid), 32'd1);
    req = 8'h00;
    cyc();
    check("hx_grant2", 32'(grant), 32'h02);
    check("hx_valid2", 32'(sel_valid), 32'd0);
    cyc();

    // Two requesters held with ready; behaviour depends on burst lock
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req   = 8'h0C;
    cyc();
    check("lk_sel0", 32'(sel), 32'd2);
`ifdef RR_SELECT_LOCK_EN
    cyc();
    check("lk_grant_a", 32'(grant), 32'h04);
    check("lk_sel_a", 32'(sel), 32'd2);
    cyc();
    check("lk_grant_b", 32'(grant), 32'h04);
    check("lk_sel_b", 32'(sel), 32'd2);
    req = 8'h08;
    cyc();
    check("lk_grant_c", 32'(grant), 32'h04);
    check("lk_sel_c", 32'(sel), 32'd3);
`else
    cyc();
    check("rr_grant_a", 32'(grant), 32'h04);
    check("rr_sel_a", 32'(sel), 32'd3);
    cyc();
    check("rr_grant_b", 32'(grant), 32'h08);
    check("rr_sel_b", 32'(sel), 32'd2);
    req = 8'h08;
    cyc();
    check("rr_grant_c", 32'(grant), 32'h04);
    check("rr_sel_c", 32'(sel), 32'd3);
`endif

    // Single requester re-offered every cycle
    req = 8'h10;
    cyc();
    check("one_grant_a", 32'(grant), 32'h08);
    check("one_sel_a", 32'(sel), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("one_grant", 32'(grant), 32'h10);
      check("one_sel", 32'(sel), 32'd4);
      check("one_valid", 32'(sel_valid), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_select_encoder.md
Name: rr_select_encoder

Overview:
- Sequential 8-to-3 select encoder.
- Sits directly upstream of the team's 8:1 data mux; drives its 3-bit select.
- Scans 8 request lines round-robin and presents the winning index with a valid/ready handshake.
- Holds the select stable until the downstream stage consumes it, with an optional-disable timeout so a stalled consumer cannot wedge the scanner.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 (select width 3), not overridable.
- TIMEOUT_CYC, 15, cycles an offer may wait for sel_ready before being withdrawn; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req  in  8  request vector; bit k = channel k wants the mux.
- sel  out  3  offered channel index, feeds mux select S.
- sel_valid  out  1  sel is a valid offer.
- sel_ready  in  1  downstream accepts sel this cycle.
- grant  out  8  one-hot of sel; one-cycle pulse on handshake cycle +1.
- timeout  out  1  one-cycle pulse when an offer is withdrawn.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, ptr=0, sel=0, sel_valid=0, grant=0, timeout=0, wait_cnt=0. Reset mid-offer drops sel_valid the next cycle with no grant and no timeout pulse.
- Pick function: first k in order ptr, ptr+1, ..., ptr+7 (mod 8) with req[k]=1; any = |req.
- IDLE:
  - If any: sel<=pick, sel_valid<=1, wait_cnt<=0, go to OFFER.
  - Latency: req to sel_valid is 1 cycle.
- OFFER, handshake (sel_valid & sel_ready):
  - grant<=onehot(sel) next cycle; ptr<=sel+1 (3-bit wrap, 7 to 0).
  - Re-pick in the same cycle using the new ptr and current req. If any, stay in OFFER with the new sel (back-to-back, 1 grant/cycle). Otherwise sel_valid<=0 and go to IDLE.
- OFFER, no handshake:
  - sel and sel_valid held stable. Deassertion of req[sel] does not retract the offer.
  - wait_cnt increments.
- Timeout (TIMEOUT_CYC>0): no handshake and wait_cnt==TIMEOUT_CYC-1 causes sel_valid<=0, timeout pulse, ptr<=sel+1, go to IDLE.
- Handshake coincident with timeout expiry: handshake wins; no timeout pulse.
- Single active requester: re-offered every cycle while asserted.
- All req=0 in IDLE: stay in IDLE, outputs unchanged.
- sel is X-free at all times; it holds its last value while sel_valid=0.

Optional Feature:
- Macro: RR_SELECT_LOCK_EN.
- Defined: after a handshake for channel k, if req[k] is still 1 in that cycle, ptr is not advanced and k is re-offered (burst lock). Lock releases when req[k] drops; ptr then becomes k+1. A timeout always releases the lock.
- Undefined: strict round-robin as above.

Decomposition:
- Package rr_select_pkg holds:
  - state enum {IDLE, OFFER};
  - constants N_REQ=8 and SEL_W=3;
  - onehot function for 3-bit to 8-bit.
- Sub-module rr_pick: combinational rotate-and-priority-find.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Instantiated once.

Test Plan:
- Reset then req=8'h00 for 5 cycles: sel_valid=0, grant=0 throughout; then rst_n=0 mid-OFFER drops sel_valid next cycle with no grant.
- req=8'hFF, sel_ready=1 constantly: sel sequence 0,1,2,...,7,0 on consecutive cycles; grant walks 01,02,...,80,01.
- req=8'h81, ptr=0, ready=1: grants alternate 0,7,0,7 (wrap-around check).
- req=8'h10, sel_ready=0 for 3 cycles, then 1: sel=4 held stable 4 cycles, single grant=8'h10; drop req[4] during the stall and the offer still completes.
- TIMEOUT_CYC=15, req=8'h06, sel_ready=0: sel=1 for 15 cycles, then timeout pulse, sel_valid=0. Next offer is sel=2. With ready asserted on the expiry cycle: grant, no timeout.
- RR_SELECT_LOCK_EN defined, req=8'h0C held, ready=1: sel=2 repeated. Drop req[2]: sel=3 next.
